// File: rtl/led_display_sched.sv
// led_display_sched: shows an N-bit word on 8 LEDs, one byte at a time.
// Two request sources (A over B) share the display.
// Each byte is held for a latched dwell time. Each frame ends with a blank
// gap of the same length, during which the next frame may be captured
// back-to-back.
module led_display_sched #(
    parameter int N  = 264,
    parameter int DW = 30,
    localparam int NB = N / 8,
    localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [N-1:0]  data_a,
    input  logic          req_b,
    input  logic [N-1:0]  data_b,
    input  logic [DW-1:0] dwell,
    input  logic          abort,
    output logic [7:0]    leds,
    output logic [1:0]    grant,
    output logic [IW-1:0] byte_idx,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [DW-1:0] DW_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [N-1:0]  shift_reg;
    logic [DW-1:0] cnt;
    logic [DW-1:0] d_lat;
    logic [IW-1:0] idx;
    logic [1:0]    grant_r;
    logic          pend_a;
    logic          pend_b;

    logic cnt_last;
    logic last_byte;
    logic last_gap;
    logic abort_act;
    logic any_req;
    logic capture;
    logic cap_a;
    logic cap_b;

    // A dwell of zero would never terminate a byte, so it is lifted to one.
    function automatic logic [DW-1:0] clamp_dwell(input logic [DW-1:0] v);
        return (v == '0) ? DW_ONE : v;
    endfunction

    // Decode end-of-byte / end-of-gap and who (if anyone) is captured this cycle.
    always_comb begin
        cnt_last  = (cnt == (d_lat - DW_ONE));
        last_byte = (idx == IW'(NB - 1));
        last_gap  = (state == GAP) && cnt_last;
        abort_act = abort && (state != IDLE);
        any_req   = req_a | pend_a | req_b | pend_b;
        capture   = ((state == IDLE) || last_gap) && any_req && !abort_act;
        cap_a     = capture && (req_a || pend_a);
        cap_b     = capture && !cap_a;
    end

    // Scheduler state, pending flags and display datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            d_lat     <= DW_ONE;
            idx       <= '0;
            grant_r   <= 2'b00;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
        end else begin
            // A request that is not served this cycle is remembered once.
            pend_a <= cap_a ? 1'b0 : (pend_a | req_a);
            pend_b <= cap_b ? 1'b0 : (pend_b | req_b);

            if (abort_act) begin
                state   <= IDLE;
                grant_r <= 2'b00;
                idx     <= '0;
                cnt     <= '0;
            end else if (capture) begin
                shift_reg <= cap_a ? data_a : data_b;
                grant_r   <= cap_a ? 2'b01 : 2'b10;
                d_lat     <= clamp_dwell(dwell);
                idx       <= '0;
                cnt       <= '0;
                state     <= SHOW;
            end else begin
                case (state)
                    SHOW: begin
                        if (cnt_last) begin
                            cnt <= '0;
                            if (last_byte) begin
                                state <= GAP;
                            end else begin
                                shift_reg <= {shift_reg[7:0], shift_reg[N-1:8]};
                                idx       <= idx + IW'(1);
                            end
                        end else begin
                            cnt <= cnt + DW_ONE;
                        end
                    end
                    GAP: begin
                        if (cnt_last) begin
                            state   <= IDLE;
                            grant_r <= 2'b00;
                            idx     <= '0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + DW_ONE;
                        end
                    end
                    IDLE: begin
                        cnt <= '0;
                    end
                    default: begin
                        state   <= IDLE;
                        grant_r <= 2'b00;
                        idx     <= '0;
                        cnt     <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs are decoded from registered state; LEDs are dark outside SHOW.
    always_comb begin
        leds       = (state == SHOW) ? shift_reg[7:0] : 8'h00;
        grant      = grant_r;
        byte_idx   = idx;
        busy       = (state != IDLE);
        frame_done = last_gap && !abort && !rst;
    end

endmodule

// File: tb/tb_led_display_sched.sv
// tb_led_display_sched: directed checks of led_display_sched with N=32, DW=8.
module tb_led_display_sched;

    localparam int N  = 32;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          req_a;
    logic [N-1:0]  data_a;
    logic          req_b;
    logic [N-1:0]  data_b;
    logic [DW-1:0] dwell;
    logic          abort;
    logic [7:0]    leds;
    logic [1:0]    grant;
    logic [1:0]    byte_idx;
    logic          busy;
    logic          frame_done;

    int total;
    int bad;

    led_display_sched #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .data_a     (data_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .dwell      (dwell),
        .abort      (abort),
        .leds       (leds),
        .grant      (grant),
        .byte_idx   (byte_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_leds"}, {24'h0, leds}, 32'h0);
        chk({tag, "_grant"}, {30'h0, grant}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_idx"}, {30'h0, byte_idx}, 32'h0);
        chk({tag, "_done"}, {31'h0, frame_done}, 32'h0);
    endtask

    logic [7:0] exp1 [15];
    logic [7:0] exp2 [10];
    logic [1:0] gnt2 [10];

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        abort  = 1'b0;
        dwell  = 8'd3;
        data_a = 32'h44332211;
        data_b = 32'hDDCCBBAA;
        exp1 = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33,
                 8'h33, 8'h44, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00};
        exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        gnt2 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};

        // Reset state
        tick();
        tick();
        chk_idle("rst");
        rst = 1'b0;
        tick();
        chk_idle("post_rst");

        // Single A frame, dwell 3
        dwell = 8'd3;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk("t1_leds", {24'h0, leds}, {24'h0, exp1[i-1]});
            chk("t1_grant", {30'h0, grant}, 32'h1);
            chk("t1_done", {31'h0, frame_done}, (i == 15) ? 32'h1 : 32'h0);
            chk("t1_busy", {31'h0, busy}, 32'h1);
            tick();
        end
        chk_idle("t1_end");

        // Simultaneous A and B, dwell 1: frames run back to back
        dwell = 8'd1;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk("t2_leds", {24'h0, leds}, {24'h0, exp2[i-1]});
            chk("t2_grant", {30'h0, grant}, {30'h0, gnt2[i-1]});
            chk("t2_busy", {31'h0, busy}, 32'h1);
            chk("t2_done", {31'h0, frame_done}, (i == 5 || i == 10) ? 32'h1 : 32'h0);
            tick();
        end
        chk_idle("t2_end");

        // Dwell zero behaves as one: five-cycle frame
        dwell = 8'd0;
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("t3_leds", {24'h0, leds}, {24'h0, exp2[i+4]});
            chk("t3_idx", {30'h0, byte_idx}, (i <= 4) ? (i - 1) : 32'h3);
            chk("t3_done", {31'h0, frame_done}, (i == 5) ? 32'h1 : 32'h0);
            tick();
        end
        chk_idle("t3_end");

        // Abort at byte 2 with B pending; B follows after one idle cycle
        dwell = 8'd2;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        tick();
        tick();
        tick();
        dwell = 8'd7;
        chk("t4_idx", {30'h0, byte_idx}, 32'h2);
        chk("t4_leds", {24'h0, leds}, 32'h33);
        abort = 1'b1;
        chk("t4_done_at_abort", {31'h0, frame_done}, 32'h0);
        tick();
        abort = 1'b0;
        chk_idle("t4_after_abort");
        tick();
        chk("t4_b_grant", {30'h0, grant}, 32'h2);
        chk("t4_b_leds", {24'h0, leds}, 32'hAA);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("t4_clean");

        // Reset mid-frame with A pending; stays idle afterwards
        dwell = 8'd2;
        req_a = 1'b1;
        tick();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        chk("t5_busy", {31'h0, busy}, 32'h1);
        rst   = 1'b1;
        req_b = 1'b1;
        tick();
        rst   = 1'b0;
        req_b = 1'b0;
        chk_idle("t5_rst");
        tick();
        chk_idle("t5_hold1");
        tick();
        tick();
        chk_idle("t5_hold3");

        // Owner re-requests three times: exactly one extra frame
        dwell = 8'd1;
        req_a = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            req_a = 1'b1;
            chk("t6_grant_first", {30'h0, grant}, 32'h1);
            tick();
        end
        req_a = 1'b0;
        tick();
        chk("t6_gap_done", {31'h0, frame_done}, 32'h1);
        tick();
        chk("t6_re_grant", {30'h0, grant}, 32'h1);
        chk("t6_re_leds", {24'h0, leds}, 32'h11);
        tick();
        tick();
        tick();
        tick();
        chk("t6_re_done", {31'h0, frame_done}, 32'h1);
        chk("t6_re_leds_gap", {24'h0, leds}, 32'h0);
        tick();
        chk_idle("t6_end");
        tick();
        tick();
        chk_idle("t6_end2");

        // Abort in IDLE is ignored; the request is still captured
        dwell = 8'd1;
        abort = 1'b1;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        chk("t7_grant", {30'h0, grant}, 32'h1);
        chk("t7_leds", {24'h0, leds}, 32'h11);
        tick();
        abort = 1'b0;
        chk_idle("t7_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_display_sched.md
LED_DISPLAY_SCHED -- requirements
Module: led_display_sched

Interface
REQ-001 SHALL have parameter N, default 264, meaning width of each displayed word; N SHALL be a multiple of 8, NB = N/8 bytes.
REQ-002 SHALL have parameter DW, default 30, meaning width of the dwell-time input.
REQ-003 SHALL have port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_a  in  1  display request from source A (PUF response), higher priority.
REQ-006 SHALL have port data_a  in  N  source A word; SHALL be sampled only in the capture cycle.
REQ-007 SHALL have port req_b  in  1  display request from source B (challenge), lower priority.
REQ-008 SHALL have port data_b  in  N  source B word; SHALL be sampled only in the capture cycle.
REQ-009 SHALL have port dwell  in  DW  cycles per byte; 0 SHALL be treated as 1; latched at capture.
REQ-010 SHALL have port abort  in  1  terminate the current frame.
REQ-011 SHALL have port leds  out  8  displayed byte.
REQ-012 SHALL have port grant  out  2  one-hot owner: 01 = A, 10 = B, 00 = none.
REQ-013 SHALL have port byte_idx  out  clog2(NB)  index of the byte shown.
REQ-014 SHALL have port busy  out  1  high in SHOW or GAP.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of a frame.

Function
REQ-016 SHALL implement states IDLE, SHOW and GAP.
REQ-017 Pending flags pend_a and pend_b SHALL be set by req_x=1 in any cycle that does not capture source x, and cleared when x is captured.
REQ-018 Capture SHALL occur in IDLE, or on the last GAP cycle, if req_a|pend_a|req_b|pend_b; A SHALL win over B.
REQ-019 Capture SHALL load the shift register with the winner's data, set grant, latch D = max(dwell,1), zero byte_idx and the dwell counter, and enter SHOW next cycle.
REQ-020 In SHOW, leds SHALL equal shift_reg[7:0]; each byte SHALL be held exactly D cycles.
REQ-021 After D cycles, the shift register SHALL rotate right by 8 (byte k+1 to [7:0]) and byte_idx SHALL increment.
REQ-022 After byte NB-1 has been held D cycles, the block SHALL enter GAP.
REQ-023 GAP SHALL last D cycles with leds=0; grant SHALL be held through GAP.
REQ-024 frame_done SHALL pulse on the last GAP cycle.
REQ-025 If no capture occurs on the last GAP cycle, the next state SHALL be IDLE with grant=00.
REQ-026 Capture latency: request seen in IDLE at cycle t -> leds = byte 0 at t+1.
REQ-027 Per-frame length SHALL be exactly NB*D + D cycles from first SHOW cycle to the cycle after frame_done.
REQ-028 A request from the owner during its own frame SHALL set its pend flag, giving one re-display; repeated requests SHALL NOT queue more than one.
REQ-029 abort in SHOW or GAP SHALL force IDLE next cycle (leds=0, grant=00, byte_idx=0), SHALL retain pend flags, and SHALL NOT pulse frame_done.
REQ-030 abort in IDLE SHALL have no effect; abort SHALL take priority over capture in the same cycle.
REQ-031 The dwell counter SHALL be DW bits wide and compare against D; a dwell change mid-frame SHALL have no effect.
REQ-032 In IDLE: leds=0, grant=00, busy=0, byte_idx=0.

Reset
REQ-033 rst=1 SHALL, on the next edge, set state IDLE and clear leds, grant, byte_idx, busy, frame_done, pend_a, pend_b, the shift register and counters.
REQ-034 rst SHALL take priority over abort, capture and requests, including mid-frame; requests asserted during rst SHALL be discarded.

Verification (N=32, NB=4, DW=8)
REQ-035 Single A frame: dwell=3, data_a=0x44332211, req_a pulse at t. Required: leds = 11,11,11,22x3,33x3,44x3, then 00x3; frame_done at t+15; grant=01 for t+1..t+15.
REQ-036 Simultaneous requests: req_a=req_b=1 in IDLE, dwell=1, data_b=0xDDCCBBAA. Required: A frame first (grant=01), then B captured on A's frame_done cycle; leds=AA on the next cycle with grant=10; no IDLE gap between frames.
REQ-037 Dwell zero: dwell=0. Required: each byte is held 1 cycle; GAP is 1 cycle; frame length is 5 cycles.
REQ-038 Abort mid-frame: abort at byte_idx=2 with pend_b set. Required: next cycle IDLE, leds=0, no frame_done; following cycle B is captured.
REQ-039 Reset mid-frame: rst in SHOW with pend_a=1. Required: all outputs 0 and pend cleared; remains IDLE after rst drops with no requests.
REQ-040 Self re-request: req_a pulsed three times during its own frame. Required: exactly one additional A frame follows, then IDLE.
